pwm_compare: RTL

PWM_COMPARE -- requirements
Module: pwm_compare

---
 rtl/pwm_compare.sv | 107 ++++++++++
 1 files changed

// File: rtl/pwm_compare.sv
// PWM comparator: registered compare of an upstream count against an active duty,
// with a single-entry shadow register that is applied only at period boundaries.
module pwm_compare #(
  parameter int NUMBITS = 4,
  parameter int UBOUND  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUMBITS-1:0] count,
  input  logic               enable,
  input  logic               cfg_valid,
  input  logic [NUMBITS:0]   cfg_duty,
  output logic               cfg_ready,
  output logic               pwm_out,
  output logic               period_start,
  output logic               cfg_applied
);

  localparam logic [NUMBITS:0]   DUTY_MAX   = (NUMBITS+1)'(UBOUND);
  localparam logic [NUMBITS-1:0] COUNT_LAST = NUMBITS'(UBOUND - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN
  } state_t;

  // Requested duties above the period length saturate to always-high.
  function automatic logic [NUMBITS:0] sat_duty(input logic [NUMBITS:0] duty);
    return (duty > DUTY_MAX) ? DUTY_MAX : duty;
  endfunction

  state_t           state_q, state_d;
  logic [NUMBITS:0] shadow_q, shadow_d;
  logic [NUMBITS:0] active_duty_q, active_duty_d;
  logic             pending_q, pending_d;
  logic             pwm_q, pwm_d;
  logic             period_start_q, period_start_d;
  logic             cfg_applied_q, cfg_applied_d;

  logic in_period;
  logic boundary;
  logic xfer;
  logic apply;

  always_comb begin
    in_period      = (state_q != IDLE);
    boundary       = in_period && (count == COUNT_LAST);
    xfer           = cfg_valid && !pending_q;
    apply          = boundary && pending_q;

    state_d        = state_q;
    shadow_d       = shadow_q;
    active_duty_d  = active_duty_q;
    pending_d      = pending_q;
    pwm_d          = 1'b0;
    period_start_d = 1'b0;
    cfg_applied_d  = apply;

    case (state_q)
      IDLE:    if (enable) state_d = ARM;
      ARM:     if (!enable) state_d = IDLE;
               else if (boundary) state_d = RUN;
      RUN:     if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A transfer can only coincide with a boundary when nothing is pending,
    // so it naturally waits for the following boundary.
    if (apply) begin
      active_duty_d = shadow_q;
      pending_d     = 1'b0;
    end else if (xfer) begin
      shadow_d  = sat_duty(cfg_duty);
      pending_d = 1'b1;
    end

    period_start_d = boundary && enable;
    pwm_d          = (state_q == RUN) && enable && ({1'b0, count} < active_duty_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      shadow_q       <= '0;
      active_duty_q  <= '0;
      pending_q      <= 1'b0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
      cfg_applied_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      active_duty_q  <= active_duty_d;
      pending_q      <= pending_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      cfg_applied_q  <= cfg_applied_d;
    end
  end

  assign cfg_ready    = !pending_q;
  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;
  assign cfg_applied  = cfg_applied_q;

endmodule
